// File: rtl/matrix_operand_bank.sv
// Two N x N operand matrices (W, X) loaded serially, then streamed as N outer-product
// steps: step k drives column k of W and row k of X across N parallel lanes.
//
// state  | meaning
// -------+---------------------------------------------------------------
// LOAD   | accepting elements until both matrices hold N*N entries
// FULL   | both matrices loaded, waiting for out_req
// STREAM | presenting steps 0..N-1 to the MAC array under out_ready
module matrix_operand_bank #(
    parameter  int N      = 3,
    parameter  int DATA_W = 4,
    localparam int CNT_W  = $clog2(N * N + 1),
    localparam int STEP_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  clear_n,
    input  logic                  soft_clear,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  load_done,
    output logic                  start,
    input  logic                  out_req,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [STEP_W-1:0]     out_step,
    output logic                  out_last,
    output logic [N*DATA_W-1:0]   out_w,
    output logic [N*DATA_W-1:0]   out_x,
    output logic                  ovf_err
);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_FULL   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(N * N);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N - 1);

    logic [DATA_W-1:0] w_mem [N*N];
    logic [DATA_W-1:0] x_mem [N*N];

    state_t            state, state_n;
    logic [CNT_W-1:0]  w_cnt, x_cnt, w_cnt_n, x_cnt_n;
    logic [STEP_W-1:0] step, step_n;
    logic              ovf_q;
    logic              load_done_q;
    logic              clr;
    logic              sel_full;
    logic              accept;
    logic              w_we, x_we;

    assign clr = !clear_n || soft_clear;

    always_comb begin
        state_n  = state;
        step_n   = step;
        w_cnt_n  = w_cnt;
        x_cnt_n  = x_cnt;
        w_we     = 1'b0;
        x_we     = 1'b0;
        sel_full = in_sel ? (x_cnt == FULL_CNT) : (w_cnt == FULL_CNT);
        // in_ready is masked during any clear so nothing appears accepted on a clearing edge
        in_ready = (state == S_LOAD) && !sel_full && !clr;
        accept   = in_valid && in_ready;

        if (accept) begin
            if (in_sel) begin
                x_we    = 1'b1;
                x_cnt_n = x_cnt + CNT_W'(1);
            end else begin
                w_we    = 1'b1;
                w_cnt_n = w_cnt + CNT_W'(1);
            end
        end

        case (state)
            S_LOAD: begin
                if ((w_cnt_n == FULL_CNT) && (x_cnt_n == FULL_CNT))
                    state_n = S_FULL;
            end
            S_FULL: begin
                if (out_req) begin
                    state_n = S_STREAM;
                    step_n  = '0;
                end
            end
            S_STREAM: begin
                if (out_ready) begin
                    if (step == LAST_STEP) begin
                        state_n = S_FULL;
                        step_n  = '0;
                    end else begin
                        step_n = step + STEP_W'(1);
                    end
                end
            end
            default: state_n = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= S_LOAD;
            step        <= '0;
            w_cnt       <= '0;
            x_cnt       <= '0;
            ovf_q       <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state       <= state_n;
            step        <= step_n;
            w_cnt       <= w_cnt_n;
            x_cnt       <= x_cnt_n;
            load_done_q <= load_done;
            if (in_valid && sel_full)
                ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < N * N; i++) begin
                w_mem[i] <= '0;
                x_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N * N; i++) begin
                if (w_we && (w_cnt == CNT_W'(i)))
                    w_mem[i] <= in_data;
                if (x_we && (x_cnt == CNT_W'(i)))
                    x_mem[i] <= in_data;
            end
        end
    end

    assign load_done = (state != S_LOAD);
    // load_done only falls via a clear, so replays never re-trigger start
    assign start     = load_done && !load_done_q;
    assign out_valid = (state == S_STREAM);
    assign out_step  = out_valid ? step : '0;
    assign out_last  = out_valid && (step == LAST_STEP);
    assign ovf_err   = ovf_q;

    // Lane i of W takes W[i][k] (column k); lane j of X takes X[k][j] (row k).
    always_comb begin
        out_w = '0;
        out_x = '0;
        if (out_valid) begin
            for (int s = 0; s < N; s++) begin
                if (step == STEP_W'(s)) begin
                    for (int l = 0; l < N; l++) begin
                        out_w[l*DATA_W +: DATA_W] = w_mem[l*N + s];
                        out_x[l*DATA_W +: DATA_W] = x_mem[s*N + l];
                    end
                end
            end
        end
    end

endmodule
